// File: rtl/exdeword_if.sv
// rtl/exdeword_if.sv - exbus word-in / byte-out handshake bundle for exdeword
interface exdeword_if;
  logic        i_stb;
  logic [34:0] i_word;
  logic        i_last;
  logic        o_busy;
  logic        o_stb;
  logic [7:0]  o_byte;
  logic        o_last;
  logic        i_busy;

  modport slave (
    input  i_stb, i_word, i_last, i_busy,
    output o_busy, o_stb, o_byte, o_last
  );

  modport master (
    output i_stb, i_word, i_last, i_busy,
    input  o_busy, o_stb, o_byte, o_last
  );
endinterface

// File: rtl/exdeword.sv
// rtl/exdeword.sv - 35-bit exbus word to 7-bits-per-byte serializer
// EXDEWORD_SKIP_IDLE_EN: drop repeated non-last idle words that match the last idle sent.
module exdeword #(
  parameter logic OPT_LOWPOWER = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  exdeword_if.slave  bus
);

  logic [34:0] word_q, word_d;
  logic [2:0]  idx_q, idx_d;
  logic        last_q, last_d;
  logic        stb_q, stb_d;
  logic [7:0]  byte_q, byte_d;
  logic        olast_q, olast_d;

  logic        cur_special;
  logic        in_special;
  logic        final_byte;
  logic        accept;
  logic        advance;
  logic        skip;

  function automatic logic [6:0] chunk(input logic [34:0] w, input logic [2:0] i);
    case (i)
      3'd1:    chunk = w[27:21];
      3'd2:    chunk = w[20:14];
      3'd3:    chunk = w[13:7];
      3'd4:    chunk = w[6:0];
      default: chunk = w[34:28];
    endcase
  endfunction

  assign cur_special = (word_q[34:33] == 2'b11);
  assign in_special  = (bus.i_word[34:33] == 2'b11);
  assign final_byte  = cur_special || (idx_q == 3'd4);

  // Busy drops on the final byte so the next word loads without a bubble.
  assign bus.o_busy = stb_q && (!final_byte || bus.i_busy);
  assign accept     = bus.i_stb && !bus.o_busy;
  assign advance    = stb_q && !bus.i_busy;

`ifdef EXDEWORD_SKIP_IDLE_EN
  logic [6:0] lspec_q, lspec_d;

  assign skip = in_special && !bus.i_last && (bus.i_word[34:28] == lspec_q);

  always_comb begin
    lspec_d = lspec_q;
    if (accept && !skip) begin
      lspec_d = in_special ? bus.i_word[34:28] : 7'h00;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      lspec_q <= 7'h00;
    end else begin
      lspec_q <= lspec_d;
    end
  end
`else
  assign skip = 1'b0;
`endif

  // A skipped word falls through to the advance branch, which retires the final byte.
  always_comb begin
    word_d  = word_q;
    idx_d   = idx_q;
    last_d  = last_q;
    stb_d   = stb_q;
    byte_d  = byte_q;
    olast_d = olast_q;
    if (accept && !skip) begin
      word_d  = bus.i_word;
      idx_d   = 3'd0;
      last_d  = bus.i_last;
      stb_d   = 1'b1;
      byte_d  = {1'b1, bus.i_word[34:28]};
      olast_d = bus.i_last && in_special;
    end else if (advance) begin
      if (final_byte) begin
        stb_d   = 1'b0;
        olast_d = 1'b0;
        idx_d   = 3'd0;
      end else begin
        idx_d   = idx_q + 3'd1;
        byte_d  = {1'b0, chunk(word_q, idx_q + 3'd1)};
        olast_d = last_q && (idx_q == 3'd3);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      word_q  <= '0;
      idx_q   <= 3'd0;
      last_q  <= 1'b0;
      stb_q   <= 1'b0;
      byte_q  <= 8'h00;
      olast_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      stb_q   <= stb_d;
      byte_q  <= byte_d;
      olast_q <= olast_d;
    end
  end

  assign bus.o_stb  = stb_q;
  assign bus.o_byte = (OPT_LOWPOWER && !stb_q) ? 8'h00 : byte_q;
  assign bus.o_last = olast_q;

endmodule

// File: tb/tb_exdeword.sv
// tb/tb_exdeword.sv - directed self-checking bench for exdeword
module tb_exdeword;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] q_byte[$];
  logic       q_last[$];
  int         q_cyc[$];
  logic [7:0] exp_b [0:9];

  localparam logic [34:0] W1 = 35'h0_1234_5678;
  localparam logic [34:0] W2 = 35'h2_AAAA_5555;
  localparam logic [34:0] WS = {2'b11, 5'b00101, 28'h0};

  exdeword_if bus();

  exdeword dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && bus.o_stb && !bus.i_busy) begin
      q_byte.push_back(bus.o_byte);
      q_last.push_back(bus.o_last);
      q_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_q();
    q_byte.delete();
    q_last.delete();
    q_cyc.delete();
  endtask

  task automatic set_w1();
    exp_b[0] = 8'h81; exp_b[1] = 8'h11; exp_b[2] = 8'h51; exp_b[3] = 8'h2C; exp_b[4] = 8'h78;
  endtask

  task automatic set_w2(input int base);
    exp_b[base+0] = 8'hAA; exp_b[base+1] = 8'h55; exp_b[base+2] = 8'h29;
    exp_b[base+3] = 8'h2A; exp_b[base+4] = 8'h55;
  endtask

  task automatic send_word(input logic [34:0] w, input logic l, output bit ok, output int acc);
    ok = 1'b0;
    acc = -1;
    bus.i_stb = 1'b1;
    bus.i_word = w;
    bus.i_last = l;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!bus.o_busy) begin
        acc = cyc;
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    bus.i_stb = 1'b0;
  endtask

  task automatic wait_bytes(input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (q_byte.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_stb = 1'b0; bus.i_word = '0; bus.i_last = 1'b0; bus.i_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.o_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b expected 0", bus.o_stb); end
    checks++; if (bus.o_byte !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h expected 00", bus.o_byte); end
    checks++; if (bus.o_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", bus.o_last); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.o_busy); end
    rst = 1'b0;
    @(posedge clk); #1;
    clear_q();
  endtask

  task automatic test_data_word();
    bit ok; int acc; int nlast;
    set_w1();
    send_word(W1, 1'b1, ok, acc);
    checks++; if (!ok) begin errors++; $display("FAIL data_accept: got timeout expected accept"); end
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL data_busy_mid: got %b expected 1", bus.o_busy); end
    wait_bytes(5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL data_count: got %0d expected 5", q_byte.size()); end
    if (ok) begin
      checks++; if (q_cyc[0] !== acc + 1) begin errors++; $display("FAIL data_latency: got cycle %0d expected %0d", q_cyc[0], acc + 1); end
      nlast = 0;
      for (int i = 0; i < 5; i++) begin
        checks++; if (q_byte[i] !== exp_b[i]) begin errors++; $display("FAIL data_byte%0d: got %h expected %h", i, q_byte[i], exp_b[i]); end
        checks++; if (q_cyc[i] !== q_cyc[0] + i) begin errors++; $display("FAIL data_cycle%0d: got %0d expected %0d", i, q_cyc[i], q_cyc[0] + i); end
        if (q_last[i] === 1'b1) nlast++;
      end
      checks++; if (q_last[4] !== 1'b1 || nlast != 1) begin errors++; $display("FAIL data_last: got final=%b count=%0d expected final=1 count=1", q_last[4], nlast); end
    end
    @(posedge clk); #1;
    checks++; if (bus.o_stb !== 1'b0) begin errors++; $display("FAIL data_idle: got %b expected 0", bus.o_stb); end
    clear_q();
  endtask

  task automatic test_special();
    bit ok; int acc;
    send_word(WS, 1'b1, ok, acc);
    checks++; if (!ok) begin errors++; $display("FAIL spec_accept: got timeout expected accept"); end
    checks++; if (bus.o_stb !== 1'b1 || bus.o_byte !== 8'hE5) begin errors++; $display("FAIL spec_byte: got stb=%b byte=%h expected stb=1 byte=e5", bus.o_stb, bus.o_byte); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL spec_busy: got %b expected 0", bus.o_busy); end
    checks++; if (bus.o_last !== 1'b1) begin errors++; $display("FAIL spec_last: got %b expected 1", bus.o_last); end
    wait_bytes(1, ok);
    @(posedge clk); #1;
    checks++; if (q_byte.size() !== 1 || bus.o_stb !== 1'b0) begin errors++; $display("FAIL spec_single: got count=%0d stb=%b expected count=1 stb=0", q_byte.size(), bus.o_stb); end
    clear_q();
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2, ok; int acc1, acc2; int gaps;
    set_w1();
    set_w2(5);
    send_word(W1, 1'b0, ok1, acc1);
    send_word(W2, 1'b1, ok2, acc2);
    checks++; if (!ok1 || !ok2) begin errors++; $display("FAIL b2b_accept: got ok1=%b ok2=%b expected 1 1", ok1, ok2); end
    wait_bytes(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_count: got %0d expected 10", q_byte.size()); end
    if (ok) begin
      gaps = 0;
      for (int i = 0; i < 10; i++) begin
        if (q_cyc[i] !== q_cyc[0] + i) gaps++;
        checks++; if (q_byte[i] !== exp_b[i]) begin errors++; $display("FAIL b2b_byte%0d: got %h expected %h", i, q_byte[i], exp_b[i]); end
      end
      checks++; if (gaps != 0) begin errors++; $display("FAIL b2b_bubble: got %0d gaps expected 0", gaps); end
      checks++; if (acc2 !== q_cyc[4]) begin errors++; $display("FAIL b2b_accept_cycle: got %0d expected %0d", acc2, q_cyc[4]); end
      checks++; if (q_last[4] !== 1'b0 || q_last[9] !== 1'b1) begin errors++; $display("FAIL b2b_last: got %b %b expected 0 1", q_last[4], q_last[9]); end
    end
    @(posedge clk); #1;
    clear_q();
  endtask

  task automatic test_stall();
    bit ok; int acc; bit found;
    set_w1();
    send_word(W1, 1'b1, ok, acc);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.o_stb && bus.o_byte == 8'h51) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++; if (!found) begin errors++; $display("FAIL stall_find: got timeout expected byte 51"); end
    bus.i_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++; if (bus.o_stb !== 1'b1 || bus.o_byte !== 8'h51 || bus.o_last !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d: got stb=%b byte=%h last=%b expected 1 51 0", k, bus.o_stb, bus.o_byte, bus.o_last);
      end
    end
    bus.i_busy = 1'b0;
    wait_bytes(5, ok);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (q_byte.size() !== 5) begin errors++; $display("FAIL stall_count: got %0d expected 5", q_byte.size()); end
    if (q_byte.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (q_byte[i] !== exp_b[i]) begin errors++; $display("FAIL stall_byte%0d: got %h expected %h", i, q_byte[i], exp_b[i]); end
      end
    end
    clear_q();
  endtask

  task automatic test_reset_mid();
    bit ok; int acc; bit found;
    send_word(W1, 1'b1, ok, acc);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.o_stb && bus.o_byte == 8'h51) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rstmid_find: got timeout expected byte 51"); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.o_stb !== 1'b0 || bus.o_last !== 1'b0) begin errors++; $display("FAIL rstmid_out: got stb=%b last=%b expected 0 0", bus.o_stb, bus.o_last); end
    rst = 1'b0;
    @(posedge clk); #1;
    clear_q();
    set_w2(0);
    send_word(W2, 1'b1, ok, acc);
    wait_bytes(5, ok);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (q_byte.size() !== 5) begin errors++; $display("FAIL rstmid_count: got %0d expected 5", q_byte.size()); end
    if (q_byte.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (q_byte[i] !== exp_b[i]) begin errors++; $display("FAIL rstmid_byte%0d: got %h expected %h", i, q_byte[i], exp_b[i]); end
      end
    end
    clear_q();
  endtask

  task automatic test_skip_idle();
    bit ok; int acc; int n; int nlast;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    clear_q();
`ifdef EXDEWORD_SKIP_IDLE_EN
    n = 7;
    exp_b[0] = 8'hE5; exp_b[1] = 8'h81; exp_b[2] = 8'h11; exp_b[3] = 8'h51;
    exp_b[4] = 8'h2C; exp_b[5] = 8'h78; exp_b[6] = 8'hE5;
`else
    n = 9;
    exp_b[0] = 8'hE5; exp_b[1] = 8'hE5; exp_b[2] = 8'hE5; exp_b[3] = 8'h81;
    exp_b[4] = 8'h11; exp_b[5] = 8'h51; exp_b[6] = 8'h2C; exp_b[7] = 8'h78; exp_b[8] = 8'hE5;
`endif
    for (int k = 0; k < 3; k++) send_word(WS, 1'b0, ok, acc);
    send_word(W1, 1'b0, ok, acc);
    send_word(WS, 1'b1, ok, acc);
    wait_bytes(n, ok);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (q_byte.size() !== n) begin errors++; $display("FAIL skip_count: got %0d expected %0d", q_byte.size(), n); end
    if (q_byte.size() == n) begin
      nlast = 0;
      for (int i = 0; i < n; i++) begin
        checks++; if (q_byte[i] !== exp_b[i]) begin errors++; $display("FAIL skip_byte%0d: got %h expected %h", i, q_byte[i], exp_b[i]); end
        if (q_last[i] === 1'b1) nlast++;
      end
      checks++; if (q_last[n-1] !== 1'b1 || nlast != 1) begin errors++; $display("FAIL skip_last: got final=%b count=%0d expected 1 1", q_last[n-1], nlast); end
    end
    clear_q();
  endtask

  initial begin
    test_reset();
    test_data_word();
    test_special();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_skip_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
